// File: rtl/spi_data_fifo_pkg.sv
// Shared SPI definitions used by the data FIFO stage: bus width, FIFO depth,
// APB-slave request bundle and the status record reported to CR/SR.
package spi_data_fifo_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 32;
  localparam int unsigned SPI_FIFO_DEPTH = 8;
  localparam int unsigned SPI_FIFO_LW    = $clog2(SPI_FIFO_DEPTH) + 1;

  typedef logic [SPI_DATA_WIDTH-1:0] spi_bus_t;

  typedef struct packed {
    logic tfifo_wen;
    logic rfifo_ren;
  } as2sd_t;

  typedef struct packed {
    logic [SPI_FIFO_LW-1:0] level;
    logic                   empty;
    logic                   full;
    logic                   ovf;
    logic                   unf;
  } fifo_stat_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Generic show-ahead single-clock FIFO with synchronous flush and sticky
// overflow/underflow flags. Pointers carry one extra wrap bit.
module spi_sync_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned DW    = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  input  logic          err_clr,
  output logic [DW-1:0] head,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  logic [DW-1:0] mem [DEPTH];
  logic [LW-1:0] wp;
  logic [LW-1:0] rp;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;
  logic          unf_set;

  always_comb begin
    empty = (wp == rp);
    full  = (wp[LW-1] != rp[LW-1]) && (wp[AW-1:0] == rp[AW-1:0]);
    level = wp - rp;
    head  = empty ? '0 : mem[rp[AW-1:0]];
  end

  // A pop on a full FIFO frees the slot the same edge, so a paired push fits.
  always_comb begin
    do_push = !flush && push && (!full || pop);
    do_pop  = !flush && pop && !empty;
    ovf_set = !flush && push && full && !pop;
    unf_set = !flush && pop && empty;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      rp <= wp;
    end else begin
      if (do_push) wp <= wp + LW'(1);
      if (do_pop)  rp <= rp + LW'(1);
    end
  end

  // Set wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~err_clr);
      unf <= unf_set | (unf & ~err_clr);
    end
  end

endmodule

// File: rtl/spi_data_fifo.sv
// SPI data buffering stage between the APB slave and the shift engine:
// TX and RX show-ahead FIFOs with levels, flags and sticky errors.
module spi_data_fifo
  import spi_data_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = SPI_FIFO_DEPTH,
  parameter  int unsigned DW    = SPI_DATA_WIDTH,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          tfifo_wen,
  input  logic [DW-1:0] wdata,
  input  logic          rfifo_ren,
  input  logic          apb_access,
  output logic [DW-1:0] rfifo_out,
  input  logic          tx_pop,
  output logic [DW-1:0] tx_data,
  input  logic          rx_push,
  input  logic [DW-1:0] rx_data,
  input  logic          tx_flush,
  input  logic          rx_flush,
  input  logic          err_clr,
  output logic [LW-1:0] tx_level,
  output logic [LW-1:0] rx_level,
  output logic          tx_empty,
  output logic          tx_full,
  output logic          rx_empty,
  output logic          rx_full,
  output logic          tx_ovf,
  output logic          rx_ovf,
  output logic          rx_unf,
  output logic          tx_unf
);

  as2sd_t req;
  logic   rx_pop;

  // rfifo_ren is address decode only; the pop lands on the edge closing the
  // access phase, while prdata samples the still-unchanged head.
  always_comb begin
    req.tfifo_wen = tfifo_wen;
    req.rfifo_ren = rfifo_ren;
    rx_pop        = req.rfifo_ren && apb_access;
  end

  spi_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_tx_fifo (
    .clk       (pclk),
    .rst       (preset),
    .push      (req.tfifo_wen),
    .push_data (wdata),
    .pop       (tx_pop),
    .flush     (tx_flush),
    .err_clr   (err_clr),
    .head      (tx_data),
    .level     (tx_level),
    .empty     (tx_empty),
    .full      (tx_full),
    .ovf       (tx_ovf),
    .unf       (tx_unf)
  );

  spi_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_rx_fifo (
    .clk       (pclk),
    .rst       (preset),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .flush     (rx_flush),
    .err_clr   (err_clr),
    .head      (rfifo_out),
    .level     (rx_level),
    .empty     (rx_empty),
    .full      (rx_full),
    .ovf       (rx_ovf),
    .unf       (rx_unf)
  );

endmodule

// File: tb/tb_spi_data_fifo.sv
// Directed plus randomized checks of spi_data_fifo against a queue-based
// reference model of the TX and RX buffers.
module tb_spi_data_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          pclk = 1'b0;
  logic          preset;
  logic          tfifo_wen;
  logic [DW-1:0] wdata;
  logic          rfifo_ren;
  logic          apb_access;
  logic [DW-1:0] rfifo_out;
  logic          tx_pop;
  logic [DW-1:0] tx_data;
  logic          rx_push;
  logic [DW-1:0] rx_data;
  logic          tx_flush;
  logic          rx_flush;
  logic          err_clr;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_ovf, rx_ovf, rx_unf, tx_unf;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  // Index 0 models TX, index 1 models RX.
  logic [DW-1:0] q [2][$];
  bit            m_ovf [2];
  bit            m_unf [2];

  spi_data_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .tfifo_wen  (tfifo_wen),
    .wdata      (wdata),
    .rfifo_ren  (rfifo_ren),
    .apb_access (apb_access),
    .rfifo_out  (rfifo_out),
    .tx_pop     (tx_pop),
    .tx_data    (tx_data),
    .rx_push    (rx_push),
    .rx_data    (rx_data),
    .tx_flush   (tx_flush),
    .rx_flush   (rx_flush),
    .err_clr    (err_clr),
    .tx_level   (tx_level),
    .rx_level   (rx_level),
    .tx_empty   (tx_empty),
    .tx_full    (tx_full),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .tx_ovf     (tx_ovf),
    .rx_ovf     (rx_ovf),
    .rx_unf     (rx_unf),
    .tx_unf     (tx_unf)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_head(input int i);
    return (q[i].size() > 0) ? q[i][0] : '0;
  endfunction

  task automatic model_fifo(input int i, input bit push, input logic [DW-1:0] d,
                            input bit pop, input bit flush, input bit clr);
    bit set_o = 0;
    bit set_u = 0;
    if (flush) begin
      q[i].delete();
    end else begin
      if (pop && q[i].size() == 0) set_u = 1;
      if (push && q[i].size() == DEPTH && !pop) begin
        set_o = 1;
      end else begin
        if (pop && q[i].size() > 0) void'(q[i].pop_front());
        if (push) q[i].push_back(d);
      end
    end
    m_ovf[i] = set_o | (m_ovf[i] & ~clr);
    m_unf[i] = set_u | (m_unf[i] & ~clr);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      m_ovf[i] = 0;
      m_unf[i] = 0;
    end
  endtask

  // Apply current inputs to the model, then advance one edge (+1 settle).
  task automatic tick();
    model_fifo(0, tfifo_wen, wdata, tx_pop, tx_flush, err_clr);
    model_fifo(1, rx_push, rx_data, rfifo_ren && apb_access, rx_flush, err_clr);
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    tfifo_wen = 0; wdata = '0; rfifo_ren = 0; apb_access = 0; tx_pop = 0;
    rx_push = 0; rx_data = '0; tx_flush = 0; rx_flush = 0; err_clr = 0;
  endtask

  task automatic check_all(input string ph);
    check({ph, ".tx_level"}, 64'(tx_level), 64'(q[0].size()));
    check({ph, ".rx_level"}, 64'(rx_level), 64'(q[1].size()));
    check({ph, ".tx_empty"}, 64'(tx_empty), 64'(q[0].size() == 0));
    check({ph, ".rx_empty"}, 64'(rx_empty), 64'(q[1].size() == 0));
    check({ph, ".tx_full"},  64'(tx_full),  64'(q[0].size() == DEPTH));
    check({ph, ".rx_full"},  64'(rx_full),  64'(q[1].size() == DEPTH));
    check({ph, ".tx_data"},  64'(tx_data),  64'(m_head(0)));
    check({ph, ".rfifo_out"}, 64'(rfifo_out), 64'(m_head(1)));
    check({ph, ".tx_ovf"}, 64'(tx_ovf), 64'(m_ovf[0]));
    check({ph, ".tx_unf"}, 64'(tx_unf), 64'(m_unf[0]));
    check({ph, ".rx_ovf"}, 64'(rx_ovf), 64'(m_ovf[1]));
    check({ph, ".rx_unf"}, 64'(rx_unf), 64'(m_unf[1]));
  endtask

  initial begin
    idle_inputs();
    preset = 1;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    preset = 0;
    tick();

    // 1. reset asserted mid-cycle with data buffered
    tfifo_wen = 1; wdata = 32'hDEAD_0001; rx_push = 1; rx_data = 32'hBEEF_0001;
    tick();
    tick();
    idle_inputs();
    check_all("pre_reset");
    #4;
    preset = 1;
    model_reset();
    #1;
    check_all("reset");
    check("reset.rfifo_out0", 64'(rfifo_out), 64'h0);
    #2;
    preset = 0;
    @(posedge pclk);
    #1;

    // 2. TX fill, overflow, drain
    for (int i = 1; i <= 8; i++) begin
      tfifo_wen = 1; wdata = 32'(i * 'h11);
      tick();
    end
    check("fill.tx_full", 64'(tx_full), 64'h1);
    check("fill.tx_level", 64'(tx_level), 64'd8);
    wdata = 32'h99;
    tick();
    tfifo_wen = 0;
    check("ovf.tx_ovf", 64'(tx_ovf), 64'h1);
    check("ovf.tx_level", 64'(tx_level), 64'd8);
    check_all("ovf");
    for (int i = 1; i <= 8; i++) begin
      check("drain.tx_data", 64'(tx_data), 64'(i * 'h11));
      tx_pop = 1;
      tick();
    end
    tx_pop = 0;
    check("drain.tx_empty", 64'(tx_empty), 64'h1);
    check_all("drain");

    // 3. RX read with APB setup then access phase
    rx_push = 1; rx_data = 32'hA5A5_0001;
    tick();
    rx_data = 32'hA5A5_0002;
    tick();
    rx_push = 0; rfifo_ren = 1; apb_access = 0;
    tick();
    check("setup.rx_level", 64'(rx_level), 64'd2);
    apb_access = 1;
    check("access.head_before", 64'(rfifo_out), 64'hA5A5_0001);
    tick();
    rfifo_ren = 0; apb_access = 0;
    check("access.head_after", 64'(rfifo_out), 64'hA5A5_0002);
    check("access.rx_level", 64'(rx_level), 64'd1);

    // 4. unqualified decode never pops
    rfifo_ren = 1;
    repeat (10) tick();
    rfifo_ren = 0;
    check("decode.rx_level", 64'(rx_level), 64'd1);
    check("decode.rx_unf", 64'(rx_unf), 64'h0);
    check_all("decode");

    // 5. boundaries
    rx_push = 1;
    for (int i = 0; i < 7; i++) begin
      rx_data = $urandom;
      tick();
    end
    check("rxfull.rx_full", 64'(rx_full), 64'h1);
    rx_data = 32'hC0DE_0008; rfifo_ren = 1; apb_access = 1;
    tick();
    check("fullpp.rx_level", 64'(rx_level), 64'd8);
    check("fullpp.rx_ovf", 64'(rx_ovf), 64'h0);
    check_all("fullpp");
    rx_push = 0;
    repeat (8) begin
      check("rxdrain.head", 64'(rfifo_out), 64'(m_head(1)));
      tick();
    end
    check("rxdrain.rx_empty", 64'(rx_empty), 64'h1);
    rx_push = 1; rx_data = 32'h5A5A_5A5A;
    tick();
    rx_push = 0; rfifo_ren = 0; apb_access = 0;
    check("emptypp.rx_level", 64'(rx_level), 64'd1);
    check("emptypp.rx_unf", 64'(rx_unf), 64'h1);
    check("emptypp.head", 64'(rfifo_out), 64'h5A5A_5A5A);
    err_clr = 1;
    tick();
    err_clr = 0;
    check("errclr.rx_unf", 64'(rx_unf), 64'h0);
    check_all("errclr");
    rfifo_ren = 1; apb_access = 1;
    tick();
    err_clr = 1;
    tick();
    rfifo_ren = 0; apb_access = 0; err_clr = 0;
    check("setwins.rx_unf", 64'(rx_unf), 64'h1);
    check_all("setwins");
    err_clr = 1;
    tick();
    err_clr = 0;

    // 6. flush with coincident push, then random stream across wrap
    tfifo_wen = 1;
    for (int i = 0; i < 5; i++) begin
      wdata = $urandom;
      tick();
    end
    check("preflush.tx_level", 64'(tx_level), 64'd5);
    wdata = 32'hFFFF_0000; tx_flush = 1;
    tick();
    tfifo_wen = 0; tx_flush = 0;
    check("flush.tx_level", 64'(tx_level), 64'd0);
    check("flush.tx_empty", 64'(tx_empty), 64'h1);
    check("flush.tx_data", 64'(tx_data), 64'h0);
    check_all("flush");
    for (int n = 0; n < DEPTH * 12; n++) begin
      tfifo_wen  = ($urandom_range(0, 9) < 6);
      wdata      = $urandom;
      tx_pop     = ($urandom_range(0, 9) < 5);
      rx_push    = ($urandom_range(0, 9) < 6);
      rx_data    = $urandom;
      rfifo_ren  = ($urandom_range(0, 9) < 7);
      apb_access = ($urandom_range(0, 9) < 6);
      err_clr    = ($urandom_range(0, 19) == 0);
      tick();
      check_all("stream");
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
